// File: rtl/i2c_pkg.sv
// i2c_pkg: state codes, quarter encoding and ACK levels shared by the I2C master, ILA decode and LEDs
package i2c_pkg;
    typedef enum logic [3:0] {
        S_IDLE      = 4'd0,
        S_START     = 4'd1,
        S_ADDR      = 4'd2,
        S_ADDR_ACK  = 4'd3,
        S_WRITE     = 4'd4,
        S_WRITE_ACK = 4'd5,
        S_READ      = 4'd6,
        S_READ_ACK  = 4'd7,
        S_STOP      = 4'd8,
        S_WAIT_TX   = 4'd9,
        S_WAIT_RX   = 4'd10
    } state_t;
    localparam logic [1:0] Q0 = 2'd0;
    localparam logic [1:0] Q1 = 2'd1;
    localparam logic [1:0] Q2 = 2'd2;
    localparam logic [1:0] Q3 = 2'd3;
    localparam logic ACK  = 1'b0;
    localparam logic NACK = 1'b1;
endpackage

// File: rtl/i2c_quarter_timer.sv
// i2c_quarter_timer: divides clk into SCL quarter-bits; hold parks the timer at the start of a bit
module i2c_quarter_timer #(
    parameter int CLK_DIV = 250
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_hold,
    output logic       o_tick,
    output logic [1:0] o_quarter
);
    import i2c_pkg::*;
    localparam int W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [W-1:0] LAST = W'(CLK_DIV - 1);
    logic [W-1:0] r_cnt;
    logic [1:0]   r_q;
    assign o_tick    = !i_hold && r_cnt == LAST;
    assign o_quarter = r_q;
    // clock divider and quarter index, both cleared while held so a bit restarts cleanly at Q0
    always_ff @(posedge i_clk) begin
        if (i_reset || i_hold) begin
            r_cnt <= '0;
            r_q   <= Q0;
        end else if (o_tick) begin
            r_cnt <= '0;
            r_q   <= r_q + 2'd1;
        end else begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/i2c_master_core.sv
// i2c_master_core: byte-level I2C master with TX pop / RX push handshakes and registered open-drain requests
module i2c_master_core #(
    parameter int CLK_DIV   = 250,
    parameter int MAX_BYTES = 16
) (
    input  logic       i_clk,
    input  logic       i_reset,
    input  logic       i_go,
    input  logic [6:0] i_addr,
    input  logic       i_rw,
    input  logic [4:0] i_byte_count,
    input  logic [7:0] i_tx_data,
    input  logic       i_tx_valid,
    output logic       o_tx_ready,
    output logic [7:0] o_rx_data,
    output logic       o_rx_valid,
    input  logic       i_rx_ready,
    input  logic       i_sda_in,
    output logic       o_scl,
    output logic       o_sda_out,
    output logic       o_test_out,
    output logic       o_busy,
    output logic       o_ack_error,
    output logic [3:0] o_state,
    output logic [4:0] o_phase
);
    import i2c_pkg::*;
    localparam logic [4:0] CNT_MAX = 5'(MAX_BYTES);
    state_t     r_state, w_next;
    logic [2:0] r_bit;
    logic [7:0] r_shift, r_rx_data;
    logic [4:0] r_count;
    logic       r_rw, r_ack, r_ack_error, r_tx_ready, r_rx_valid, r_scl, r_sda, r_test, r_busy;
    logic       w_tick, w_hold, w_sample, w_bit_end, w_last_bit, w_more, w_lo, w_go, w_load, w_rx_push;
    logic       w_shift_bits, w_scl, w_sda, w_test;
    logic [1:0] w_q;

    assign w_hold       = r_state == S_IDLE || r_state == S_WAIT_TX || r_state == S_WAIT_RX;
    assign w_sample     = w_tick && w_q == Q2;
    assign w_bit_end    = w_tick && w_q == Q3;
    assign w_last_bit   = r_bit == 3'd0;
    assign w_more       = r_count != 5'd0;
    assign w_lo         = w_q == Q0 || w_q == Q1;
    assign w_go         = i_go && r_state == S_IDLE;
    assign w_load       = w_next == S_WRITE && r_state != S_WRITE;
    assign w_rx_push    = w_next == S_READ_ACK && r_state != S_READ_ACK;
    assign w_shift_bits = r_state == S_ADDR || r_state == S_WRITE || r_state == S_READ;

    i2c_quarter_timer #(.CLK_DIV(CLK_DIV)) u_timer (
        .i_clk     (i_clk),
        .i_reset   (i_reset),
        .i_hold    (w_hold),
        .o_tick    (w_tick),
        .o_quarter (w_q)
    );

    // state register
    always_ff @(posedge i_clk) begin
        if (i_reset) r_state <= S_IDLE;
        else         r_state <= w_next;
    end

    // next state plus SCL/SDA/test decode; states change only at bit ends except IDLE and the WAIT states
    always_comb begin
        w_next = r_state;
        w_scl  = 1'b1;
        w_sda  = 1'b1;
        w_test = 1'b1;
        case (r_state)
            S_IDLE: if (w_go) w_next = S_START;
            S_START: begin
                w_sda = w_lo;
                if (w_bit_end) w_next = S_ADDR;
            end
            S_ADDR, S_WRITE: begin
                w_scl = !w_lo;
                w_sda = r_shift[7];
                if (w_bit_end && w_last_bit) w_next = (r_state == S_ADDR) ? S_ADDR_ACK : S_WRITE_ACK;
            end
            S_ADDR_ACK, S_WRITE_ACK: begin
                w_scl  = !w_lo;
                w_test = w_q != Q2;
                if (w_bit_end)
                    w_next = (r_ack == NACK || !w_more) ? S_STOP :
                             r_rw ? S_READ : (i_tx_valid ? S_WRITE : S_WAIT_TX);
            end
            S_WAIT_TX: begin
                w_scl = 1'b0;
                if (i_tx_valid) w_next = S_WRITE;
            end
            S_READ: begin
                w_scl  = !w_lo;
                w_test = w_q != Q2;
                if (w_bit_end && w_last_bit) w_next = i_rx_ready ? S_READ_ACK : S_WAIT_RX;
            end
            S_WAIT_RX: begin
                w_scl = 1'b0;
                if (i_rx_ready) w_next = S_READ_ACK;
            end
            S_READ_ACK: begin
                w_scl = !w_lo;
                w_sda = w_more ? ACK : NACK;
                if (w_bit_end) w_next = w_more ? S_READ : S_STOP;
            end
            S_STOP: begin
                w_scl = !w_lo;
                w_sda = w_q == Q3;
                if (w_bit_end) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    // datapath: request latching, shift register, byte counter, ACK tracking and registered pad outputs
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_bit       <= 3'd7;
            r_shift     <= '0;
            r_count     <= '0;
            r_rw        <= 1'b0;
            r_ack       <= ACK;
            r_ack_error <= 1'b0;
            r_tx_ready  <= 1'b0;
            r_rx_valid  <= 1'b0;
            r_rx_data   <= '0;
            r_scl       <= 1'b1;
            r_sda       <= 1'b1;
            r_test      <= 1'b1;
            r_busy      <= 1'b0;
        end else begin
            r_tx_ready <= w_load;
            r_rx_valid <= w_rx_push;
            r_scl      <= w_scl;
            r_sda      <= w_sda;
            r_test     <= w_test;
            r_busy     <= w_next != S_IDLE;
            if (w_go) begin
                r_shift     <= {i_addr, i_rw};
                r_rw        <= i_rw;
                r_count     <= (i_byte_count > CNT_MAX) ? CNT_MAX : i_byte_count;
                r_ack_error <= 1'b0;
                r_bit       <= 3'd7;
            end else begin
                if (w_load) r_shift <= i_tx_data;
                else if (r_state == S_READ && w_sample) r_shift <= {r_shift[6:0], i_sda_in};
                else if ((r_state == S_ADDR || r_state == S_WRITE) && w_bit_end) r_shift <= {r_shift[6:0], 1'b0};
                if (w_shift_bits && w_bit_end) r_bit <= r_bit - 3'd1;
                if (w_shift_bits && r_state != S_ADDR && w_bit_end && w_last_bit) r_count <= r_count - 5'd1;
                if (w_sample) r_ack <= i_sda_in;
                if ((r_state == S_ADDR_ACK || r_state == S_WRITE_ACK) && w_bit_end && r_ack == NACK) r_ack_error <= 1'b1;
                if (w_rx_push) r_rx_data <= r_shift;
            end
        end
    end

    assign o_tx_ready  = r_tx_ready;
    assign o_rx_valid  = r_rx_valid;
    assign o_rx_data   = r_rx_data;
    assign o_scl       = r_scl;
    assign o_sda_out   = r_sda;
    assign o_test_out  = r_test;
    assign o_busy      = r_busy;
    assign o_ack_error = r_ack_error;
    assign o_state     = r_state;
    assign o_phase     = {w_shift_bits ? r_bit : 3'd0, w_q};
endmodule

// File: tb/tb_i2c_master_core.sv
// tb_i2c_master_core: directed transactions against a bus-level slave model with hand-computed expectations
module tb_i2c_master_core;
    logic       clk = 1'b0;
    logic       i_reset = 1'b1, i_go = 1'b0, i_rw = 1'b0, i_rx_ready = 1'b1;
    logic [6:0] i_addr = '0;
    logic [4:0] i_byte_count = '0;
    logic [7:0] i_tx_data;
    logic       i_tx_valid, i_sda_in;
    logic       o_tx_ready, o_rx_valid, o_scl, o_sda_out, o_test_out, o_busy, o_ack_error;
    logic [7:0] o_rx_data;
    logic [3:0] o_state;
    logic [4:0] o_phase;

    int n_vec = 0, n_err = 0;
    logic [7:0] tx_arr [0:31];
    int tx_n = 0, tx_ptr = 0;
    logic tx_allow = 1'b1, nack_mode = 1'b0;
    int nbytes = 0;
    logic [7:0] rd_bytes [0:3];
    bit rec [$];
    logic [3:0] st_q [$];
    logic [7:0] rx_q [$];
    int k = 0, stop_cnt = 0;
    logic rw_seen = 1'b0, prev_scl = 1'b1, prev_sda = 1'b1, slave_sda = 1'b1, line;
    logic [3:0] prev_st = 4'd0;

    always #5 clk = ~clk;

    assign i_sda_in   = o_sda_out & slave_sda;
    assign i_tx_valid = tx_allow && (tx_ptr < tx_n);
    assign i_tx_data  = tx_arr[tx_ptr];

    i2c_master_core #(.CLK_DIV(4), .MAX_BYTES(16)) dut (
        .i_clk(clk), .i_reset(i_reset), .i_go(i_go), .i_addr(i_addr), .i_rw(i_rw),
        .i_byte_count(i_byte_count), .i_tx_data(i_tx_data), .i_tx_valid(i_tx_valid),
        .o_tx_ready(o_tx_ready), .o_rx_data(o_rx_data), .o_rx_valid(o_rx_valid),
        .i_rx_ready(i_rx_ready), .i_sda_in(i_sda_in), .o_scl(o_scl), .o_sda_out(o_sda_out),
        .o_test_out(o_test_out), .o_busy(o_busy), .o_ack_error(o_ack_error),
        .o_state(o_state), .o_phase(o_phase)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // slave drive for the bit about to start, nk = SCL rises seen since START
    function automatic logic slave_bit(input int nk);
        int p, idx;
        logic [7:0] b;
        p = nk % 9;
        idx = nk / 9 - 1;
        if (nk == 8) return nack_mode;
        if (nk > 8 && idx < nbytes) begin
            if (!rw_seen && p == 8) return 1'b0;
            if (rw_seen && p < 8) begin
                b = rd_bytes[idx];
                return b[7 - p];
            end
        end
        return 1'b1;
    endfunction

    function automatic logic [63:0] frame(input int base, input int i);
        logic [63:0] f = '0;
        for (int j = 0; j < 9; j++) f = {f[62:0], 1'(rec[base + 9 * i + j])};
        return f;
    endfunction

    function automatic logic [63:0] seq_pack(input int base);
        logic [63:0] v = '0;
        for (int i = base; i < st_q.size(); i++) v = {v[59:0], st_q[i]};
        return v;
    endfunction

    function automatic logic [63:0] rx_pack(input int base);
        logic [63:0] v = '0;
        for (int i = base; i < rx_q.size(); i++) v = {v[55:0], rx_q[i]};
        return v;
    endfunction

    // bus monitor and slave: records SDA on SCL rise, detects START/STOP, drives ACK/read data on SCL fall
    initial forever begin
        @(negedge clk);
        line = o_sda_out & slave_sda;
        if (o_tx_ready) tx_ptr++;
        if (o_rx_valid) rx_q.push_back(o_rx_data);
        if (o_state !== prev_st) begin
            st_q.push_back(o_state);
            prev_st = o_state;
        end
        if (prev_scl && o_scl && prev_sda && !line) k = 0;
        if (prev_scl && o_scl && !prev_sda && line) stop_cnt++;
        if (!prev_scl && o_scl) begin
            rec.push_back(line);
            if (k == 7) rw_seen = line;
            k++;
        end
        if (prev_scl && !o_scl) slave_sda = slave_bit(k);
        prev_scl = o_scl;
        prev_sda = line;
    end

    task automatic start_go(input logic [6:0] a, input logic r, input logic [4:0] c);
        @(negedge clk);
        i_addr = a;
        i_rw = r;
        i_byte_count = c;
        i_go = 1'b1;
        @(negedge clk);
        i_go = 1'b0;
    endtask

    task automatic wait_idle(input string tag, output int cyc);
        cyc = 0;
        while (o_busy && cyc < 3000) begin
            @(negedge clk);
            cyc++;
        end
        check(tag, o_busy, 1'b0);
    endtask

    task automatic wait_st(input string tag, input logic [3:0] s);
        int n = 0;
        while (o_state !== s && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check(tag, o_state, s);
    endtask

    task automatic hold_check(input string tag);
        int viol = 0;
        repeat (2) @(negedge clk);
        for (int i = 0; i < 40; i++) begin
            if (o_scl !== 1'b0) viol++;
            @(negedge clk);
        end
        check(tag, viol, 0);
    endtask

    initial begin
        int rb, tb0, sb, xb, sc0, cyc, n;
        repeat (4) @(negedge clk);
        i_reset = 1'b0;
        @(negedge clk);
        check("rst_lines", {o_scl, o_sda_out, o_test_out, o_busy, o_ack_error, o_tx_ready, o_rx_valid}, 7'b1110000);
        check("rst_state", {o_state, o_phase}, 9'd0);
        check("rst_rx_data", o_rx_data, 8'h00);

        // write two bytes, all ACKed
        tx_arr[0] = 8'hA5; tx_arr[1] = 8'h3C; tx_n = 2; nbytes = 2;
        rb = rec.size(); tb0 = tx_ptr; sc0 = stop_cnt;
        start_go(7'h50, 1'b0, 5'd2);
        wait_idle("t1_idle", cyc);
        check("t1_rises", rec.size() - rb, 28);
        check("t1_addr", frame(rb, 0), {8'hA0, 1'b0});
        check("t1_byte0", frame(rb, 1), {8'hA5, 1'b0});
        check("t1_byte1", frame(rb, 2), {8'h3C, 1'b0});
        check("t1_tx_pops", tx_ptr - tb0, 2);
        check("t1_stop", stop_cnt - sc0, 1);
        check("t1_busy_len_ok", (cyc >= 462 && cyc <= 466), 1'b1);
        check("t1_ack_err", o_ack_error, 1'b0);

        // read three bytes, master ACK, ACK, NACK
        rd_bytes[0] = 8'h11; rd_bytes[1] = 8'h22; rd_bytes[2] = 8'h33; nbytes = 3;
        rb = rec.size(); sb = st_q.size(); xb = rx_q.size(); sc0 = stop_cnt;
        start_go(7'h1D, 1'b1, 5'd3);
        wait_idle("t2_idle", cyc);
        check("t2_rises", rec.size() - rb, 37);
        check("t2_addr", frame(rb, 0), {8'h3B, 1'b0});
        check("t2_rd0", frame(rb, 1), {8'h11, 1'b0});
        check("t2_rd1", frame(rb, 2), {8'h22, 1'b0});
        check("t2_rd2", frame(rb, 3), {8'h33, 1'b1});
        check("t2_rx_cnt", rx_q.size() - xb, 3);
        check("t2_rx_data", rx_pack(xb), 24'h112233);
        check("t2_seq_len", st_q.size() - sb, 11);
        check("t2_seq", seq_pack(sb), 44'h12367676780);
        check("t2_stop", stop_cnt - sc0, 1);

        // address NACK with a TX byte pending: no pop, error set
        tx_arr[2] = 8'h77; tx_n = 3; nbytes = 1; nack_mode = 1'b1;
        rb = rec.size(); sb = st_q.size(); tb0 = tx_ptr;
        start_go(7'h2B, 1'b0, 5'd1);
        wait_idle("t3_idle", cyc);
        check("t3_ack_err", o_ack_error, 1'b1);
        check("t3_seq", seq_pack(sb), 20'h12380);
        check("t3_tx_pops", tx_ptr - tb0, 0);
        check("t3_rises", rec.size() - rb, 10);
        check("t3_addr", frame(rb, 0), {8'h56, 1'b1});
        nack_mode = 1'b0;
        repeat (5) @(negedge clk);
        check("t3_err_sticky", o_ack_error, 1'b1);
        rb = rec.size();
        start_go(7'h50, 1'b0, 5'd1);
        repeat (2) @(negedge clk);
        check("t3_err_clear", o_ack_error, 1'b0);
        wait_idle("t3b_idle", cyc);
        check("t3b_byte", frame(rb, 1), {8'h77, 1'b0});
        check("t3b_ack_err", o_ack_error, 1'b0);

        // TX FIFO empty after the address ACK
        rb = rec.size(); sb = st_q.size(); tb0 = tx_ptr;
        start_go(7'h2A, 1'b0, 5'd1);
        wait_st("t4_wait_tx", 4'd9);
        hold_check("t4_tx_scl_low");
        check("t4_still_wait_tx", o_state, 4'd9);
        tx_arr[3] = 8'h96; tx_n = 4;
        wait_idle("t4_idle", cyc);
        check("t4_addr", frame(rb, 0), {8'h54, 1'b0});
        check("t4_byte", frame(rb, 1), {8'h96, 1'b0});
        check("t4_tx_pops", tx_ptr - tb0, 1);
        check("t4_seq", seq_pack(sb), 32'h12394580);

        // RX FIFO full at the end of the byte
        rd_bytes[0] = 8'h5A; nbytes = 1; i_rx_ready = 1'b0;
        rb = rec.size(); sb = st_q.size(); xb = rx_q.size();
        start_go(7'h15, 1'b1, 5'd1);
        wait_st("t4b_wait_rx", 4'd10);
        hold_check("t4b_rx_scl_low");
        check("t4b_rx_none", rx_q.size() - xb, 0);
        i_rx_ready = 1'b1;
        wait_idle("t4b_idle", cyc);
        check("t4b_rx", rx_pack(xb), 8'h5A);
        check("t4b_rx_cnt", rx_q.size() - xb, 1);
        check("t4b_frame", frame(rb, 1), {8'h5A, 1'b1});
        check("t4b_seq", seq_pack(sb), 32'h1236A780);

        // reset during bit 4 of a data byte
        tx_arr[4] = 8'hC3; tx_arr[5] = 8'hE1; tx_n = 6; nbytes = 2;
        start_go(7'h50, 1'b0, 5'd2);
        n = 0;
        while (!(o_state == 4'd4 && o_phase[4:2] == 3'd4) && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("t5_at_bit4", {o_state, o_phase[4:2]}, {4'd4, 3'd4});
        i_reset = 1'b1;
        @(negedge clk);
        check("t5_rst_lines", {o_scl, o_sda_out, o_busy}, 3'b110);
        check("t5_rst_state", o_state, 4'd0);
        i_reset = 1'b0;
        tx_allow = 1'b0;
        repeat (3) @(negedge clk);

        // address-only probe with a go during busy that must be ignored
        nbytes = 0;
        rb = rec.size(); sb = st_q.size(); sc0 = stop_cnt;
        start_go(7'h3C, 1'b0, 5'd0);
        repeat (20) @(negedge clk);
        start_go(7'h11, 1'b1, 5'd5);
        wait_idle("t5b_idle", cyc);
        check("t5b_rises", rec.size() - rb, 10);
        check("t5b_addr", frame(rb, 0), {8'h78, 1'b0});
        check("t5b_seq", seq_pack(sb), 20'h12380);
        check("t5b_stop", stop_cnt - sc0, 1);
        check("t5b_ack_err", o_ack_error, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/i2c_master_core.md
Name: i2c_master_core

Overview:
Byte-level I2C master engine that sits directly upstream of the board top-level pad logic. It is fed by the AXI register/FIFO front-end through TX pop and RX push handshakes. It generates the open-drain requests scl, sda_out and test_out (1 = release, 0 = pull low), samples sda_in, and exports busy, ack_error, state and phase for the LEDs and the ILA.

Parameters:
CLK_DIV, 250, clocks per quarter-bit (100 MHz / (4*250) = 100 kHz SCL); minimum 2
MAX_BYTES, 16, upper limit for byte_count

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
go  in  1  one-cycle start request; ignored while busy
addr  in  7  7-bit target address, latched on accepted go
rw  in  1  0 = write, 1 = read; latched on go
byte_count  in  5  number of data bytes (0 = address-only probe); latched on go
tx_data  in  8  next write byte from TX FIFO
tx_valid  in  1  TX FIFO non-empty
tx_ready  out  1  one-cycle pop strobe; tx_data is consumed on that cycle
rx_data  out  8  received byte, valid with rx_valid
rx_valid  out  1  one-cycle push strobe
rx_ready  in  1  RX FIFO can accept a byte
sda_in  in  1  SDA pad readback
scl  out  1  SCL request
sda_out  out  1  SDA request
test_out  out  1  0 during each sample quarter, else 1
busy  out  1  transaction in progress
ack_error  out  1  sticky NACK flag
state  out  4  FSM state code
phase  out  5  {bit_idx[2:0], quarter[1:0]}

Behaviour:
- Reset values: scl=1, sda_out=1, test_out=1, busy=0, ack_error=0, state=IDLE, phase=0, tx_ready=0, rx_valid=0, rx_data=0. Reset asserted mid-transfer releases both lines on the next edge. No STOP is generated.
- Quarter timer: counts 0..CLK_DIV-1. Quarter advances on wrap. One bit = 4 quarters.
  - Q0, Q1: SCL low. SDA changes at start of Q0.
  - Q2, Q3: SCL high.
  - sda_in is sampled on the last clk of Q2.
- States and codes:
  - IDLE(0)
  - START(1): SDA falls at start of Q2 while SCL is high. SCL falls at Q0 of the next bit.
  - ADDR(2): sends {addr,rw}, MSB first, bit_idx 7..0.
  - ADDR_ACK(3)
  - WRITE(4)
  - WRITE_ACK(5)
  - READ(6): SDA released, 8 samples MSB first.
  - READ_ACK(7): master drives 0, or 1 on the last byte.
  - STOP(8): Q0/Q1 SDA low and SCL low; Q2 SCL high; SDA rises at Q3.
  - WAIT_TX(9)
  - WAIT_RX(10)
- Transitions:
  - IDLE -> START on go while !busy. Clears ack_error; busy=1 on the following cycle.
  - START -> ADDR.
  - ADDR -> ADDR_ACK.
  - ADDR_ACK, sample=1 (NACK): ack_error=1, then STOP.
  - ADDR_ACK, ACK: byte_count==0 -> STOP; rw=0 -> WRITE-prep; rw=1 -> READ.
  - WRITE-prep, tx_valid=1: tx_ready pulses for one cycle, byte is latched, then WRITE.
  - WRITE-prep, tx_valid=0: WAIT_TX, holding SCL low and SDA steady until tx_valid.
  - WRITE -> WRITE_ACK. NACK -> ack_error=1, STOP. ACK -> next byte or, after the last byte, STOP.
  - READ, end of bit 0, rx_ready=1: rx_valid pulses with rx_data, then READ_ACK.
  - READ, end of bit 0, rx_ready=0: WAIT_RX with SCL held low. rx_valid pulses on the first cycle with rx_ready=1, then READ_ACK.
  - READ_ACK -> READ for the next byte, or STOP after byte byte_count.
  - STOP -> IDLE after Q3 completes. busy=0 on the IDLE entry cycle.
- Byte counter: decrements per completed byte. byte_count > MAX_BYTES saturates to MAX_BYTES.
- go asserted while busy: ignored. Latched fields do not change.
- ack_error stays set after STOP until the next accepted go.
- phase during START/STOP: bit_idx=0. phase=0 in IDLE and WAIT states.
- sda_in is treated as synchronous (the top supplies it). No clock stretching by the slave is supported.

Decomposition:
- Package i2c_pkg holds:
  - the 4-bit state enum with the codes above (shared with the ILA decode and LED logic)
  - quarter encoding constants
  - ACK=0 and NACK=1 constants
- Sub-module i2c_quarter_timer holds the CLK_DIV counter and 2-bit quarter counter. It outputs a quarter_tick strobe, the quarter index, and a hold input used for WAIT states.

Test Plan:
1. CLK_DIV=4, write addr=0x50, byte_count=2, tx bytes 0xA5,0x3C, slave ACKs all -> SDA bitstream 0xA0,A,0xA5,A,0x3C,A.
   - Two tx_ready pulses; STOP present; busy high for 1+9*3+1 bits = 29*16 clks ±2.
   - ack_error=0.
2. Read addr=0x1D, byte_count=3, slave returns 0x11,0x22,0x33 -> rx_valid pulses ×3 with matching rx_data; master ACK,ACK,NACK; state sequence 1,2,3,6,7,6,7,6,7,8,0.
3. Address NACK (sda_in=1 in ADDR_ACK) -> ack_error=1, state goes 3->8->0, no tx_ready pulse. The next go clears ack_error.
4. Write with tx_valid low for 40 clks after ADDR_ACK -> state=9, SCL held 0 for the whole wait, then transfer resumes correctly. Repeat with rx_ready low for 40 clks -> state=10 with SCL low.
5. Assert reset during bit 4 of a data byte -> next cycle scl=1, sda_out=1, busy=0, state=0. go issued during busy is ignored, and byte_count=0 produces START, address, ACK and STOP only.
